instr_enc: RTL



---
 rtl/instr_enc.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_enc.sv
// RV32I instruction encoder: packs opcode, register, function and immediate
// fields into a 32-bit instruction word through a two-stage valid/ready
// pipeline. Immediates that the format cannot hold, and unknown opcodes,
// produce a canonical NOP with out_err set. Erroneous deliveries are counted.
module instr_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opc,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  localparam logic [6:0]  OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_R_TYPE = 7'b0110011;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // True when imm[31:lsb] are all copies of the sign bit.
  function automatic logic fits(input logic signed [31:0] imm, input int lsb);
    logic signed [31:0] t;
    t = imm >>> lsb;
    return (t == '0) || (t == '1);
  endfunction

  // Returns {err, word}; an illegal request yields the NOP word.
  function automatic logic [32:0] encode(
    input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
    input logic signed [31:0] imm);
    logic [31:0] w;
    logic        bad;
    w   = '0;
    bad = 1'b0;
    case (opc)
      OPC_R_TYPE: w = {f7, rs2, rs1, f3, rd, opc};
      OPC_I_TYPE, OPC_LOAD, OPC_JALR: begin
        w   = {imm[11:0], rs1, f3, rd, opc};
        bad = !fits(imm, 11);
      end
      OPC_STORE: begin
        w   = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
        bad = !fits(imm, 11);
      end
      OPC_BRANCH: begin
        w   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
        bad = imm[0] || !fits(imm, 12);
      end
      OPC_LUI, OPC_AUIPC: begin
        w   = {imm[31:12], rd, opc};
        bad = |imm[11:0];
      end
      OPC_JAL: begin
        w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
        bad = imm[0] || !fits(imm, 20);
      end
      default: bad = 1'b1;
    endcase
    if (bad) w = NOP_INSTR;
    return {bad, w};
  endfunction

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic               s1_valid_q;
  logic [6:0]         s1_opc_q;
  logic [4:0]         s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]         s1_f3_q;
  logic [6:0]         s1_f7_q;
  logic signed [31:0] s1_imm_q;
  logic               out_valid_q, out_err_q;
  logic [31:0]        out_instr_q;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic [32:0]        enc_d;
  logic               s2_can_load;

  // Handshake, encoding and error-count next state.
  always_comb begin
    s2_can_load = !out_valid_q || out_ready;
    in_ready    = !rst && (!s1_valid_q || s2_can_load);
    enc_d       = encode(s1_opc_q, s1_rd_q, s1_rs1_q, s1_rs2_q, s1_f3_q,
                         s1_f7_q, s1_imm_q);
    err_cnt_d   = err_cnt_q;
    if (out_valid_q && out_ready && out_err_q) err_cnt_d = sat_inc(err_cnt_q);
  end

  // ---- stage 1: raw field capture ----
  // Stage-1 valid; advances whenever the stage can take a new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           s1_valid_q <= 1'b0;
    else if (in_ready) s1_valid_q <= in_valid;
  end

  // Stage-1 fields carry no reset; they are qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_opc_q <= in_opc;
      s1_rd_q  <= in_rd;
      s1_rs1_q <= in_rs1;
      s1_rs2_q <= in_rs2;
      s1_f3_q  <= in_funct3;
      s1_f7_q  <= in_funct7;
      s1_imm_q <= in_imm;
    end
  end

  // ---- stage 2: encoded word and error flag ----
  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_can_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_err_q   <= enc_d[32];
        out_instr_q <= enc_d[31:0];
      end
    end
  end

  // Count erroneous words actually delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
